rail_fence_decryptor: RTL and testbench
=======================================

RAIL_FENCE_DECRYPTOR -- requirements
Module: rail_fence_decryptor

Interface
REQ-001 The block SHALL have parameter D_WIDTH, default 8, meaning the character width in bits.
REQ-002 The block SHALL have parameter KEY_WIDTH, default 8, meaning the key (rail count) width in bits.
REQ-003 The block SHALL have parameter MAX_NOF_CHARS, default 64, meaning the message buffer depth in characters.
REQ-004 The block SHALL have parameter MAX_RAILS, default 8, meaning the largest supported rail count.
REQ-005 The block SHALL have parameter START_DECRYPTION_TOKEN, default 8'hFA, meaning the end-of-ciphertext / start-decryption marker.
REQ-006 clk  input  1  clock; all logic on posedge.
REQ-007 rst_n  input  1  reset; rst_n is synchronous and active-low, with clock clk.
REQ-008 data_i  input  D_WIDTH  ciphertext character.
REQ-009 valid_i  input  1  data_i qualifier.
REQ-010 key  input  KEY_WIDTH  rail count.
REQ-011 ready_i  input  1  downstream accept for data_o.
REQ-012 busy  output  1  high from token acceptance until the last plaintext beat is transferred.
REQ-013 data_o  output  D_WIDTH  plaintext character.
REQ-014 valid_o  output  1  data_o qualifier.
REQ-015 err_o  output  1  single-cycle error pulse.

Function
REQ-016 States SHALL be IDLE (collect), COUNT (rail sizes), PREFIX (rail start offsets) and OUTPUT; reset enters IDLE.
REQ-017 In IDLE, each cycle with valid_i=1 and data_i != token SHALL store data_i at buffer index L and increment L.
REQ-018 When L = MAX_NOF_CHARS, further non-token characters SHALL be dropped and a sticky overflow flag set.
REQ-019 valid_i=1 with data_i = token in IDLE SHALL be accepted; the token is not stored, and key is latched in the same cycle.
REQ-020 On token acceptance with L=0, the block SHALL stay in IDLE, leave busy low and produce no output.
REQ-021 On token acceptance with L>0, busy SHALL go high on the next edge and the state SHALL move to COUNT.
REQ-022 On token acceptance with the overflow flag set, err_o SHALL pulse one cycle, the flag SHALL clear, and decryption SHALL proceed on the stored L characters.
REQ-023 A latched key of 0, 1 or >= L SHALL select pass-through: buffer order is output unchanged.
REQ-024 A latched key with 2 <= key < L and key > MAX_RAILS SHALL pulse err_o, discard the message (L:=0) and return to IDLE with busy low and no output.
REQ-025 Otherwise, COUNT SHALL walk positions p=0..L-1 through the zigzag rail sequence 0,1,..,key-1,key-2,..,1,0,.. and count characters per rail.
REQ-026 PREFIX SHALL set start[r] = sum of counts of rails 0..r-1.
REQ-027 OUTPUT SHALL re-walk p=0..L-1, emit buffer[ptr[r]] for the current rail r, then increment ptr[r].
REQ-028 The first valid_o SHALL assert no later than L+4 cycles after the token-acceptance edge.
REQ-029 A beat SHALL transfer when valid_o && ready_i; while valid_o && !ready_i, data_o and the walk state SHALL hold.
REQ-030 Back-to-back beats SHALL be produced at 1 per cycle while ready_i=1.
REQ-031 After the L-th transfer, valid_o and busy SHALL be low on the next edge, L SHALL clear, and the state SHALL return to IDLE.
REQ-032 While busy=1, valid_i SHALL be ignored (no storage) and key changes SHALL have no effect.
REQ-033 Rail/index counters SHALL be sized clog2(MAX_NOF_CHARS+1) and clog2(MAX_RAILS) bits; no wrap-around SHALL occur within legal ranges.

Reset
REQ-034 rst_n=0 at a clock edge SHALL force busy=0, valid_o=0, err_o=0, data_o=0, L=0, overflow flag cleared and state IDLE, including mid-COUNT or mid-OUTPUT.
REQ-035 Buffer contents need not be cleared by reset; they SHALL never be output before being rewritten.

Verification
REQ-036 Stimulus "HLOEL", token, key=2, ready_i=1 -> data_o sequence "HELLO"; 5 beats, 1 per cycle, then busy falls.
REQ-037 Stimulus "WECRLTEERDSOEEFEAOCAIVDEN", token, key=3 -> "WEAREDISCOVEREDFLEEATONCE"; first valid_o within 29 cycles of the token.
REQ-038 Stimulus "ABC", token with key=1, then "ABC", token with key=5 -> "ABC" both times (pass-through).
REQ-039 Stimulus 70 characters, token, key=2, MAX_NOF_CHARS=64 -> err_o pulses once and 64 decrypted beats are produced; separately, key=9 with L=20 -> err_o pulses, no valid_o, busy stays low.
REQ-040 Stimulus "HLOEL" with ready_i toggling 1,0,0,1,... -> data_o held stable while stalled and the sequence is still "HELLO".
REQ-041 Stimulus rst_n=0 asserted after the 2nd output beat -> outputs 0 next edge; a subsequent "HLOEL", token, key=2 -> "HELLO".

Source files
------------

// File: rtl/rail_fence_decryptor.sv
// Rail fence decryptor: buffers ciphertext until the start token, counts the
// characters on each rail, then re-walks the zigzag to emit plaintext.
module rail_fence_decryptor #(
    parameter int                 D_WIDTH                = 8,
    parameter int                 KEY_WIDTH              = 8,
    parameter int                 MAX_NOF_CHARS          = 64,
    parameter int                 MAX_RAILS              = 8,
    parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key,
    input  logic                 ready_i,
    output logic                 busy,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o,
    output logic                 err_o
);
    localparam int LEN_W  = $clog2(MAX_NOF_CHARS + 1);
    localparam int ADDR_W = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;
    localparam int RAIL_W = (MAX_RAILS > 1) ? $clog2(MAX_RAILS) : 1;
    localparam int CMP_W  = ((KEY_WIDTH > LEN_W) ? KEY_WIDTH : LEN_W) + 1;

    typedef enum logic [1:0] {IDLE, COUNT, PREFIX, OUTPUT} state_t;

    state_t                           state_reg;
    logic [LEN_W-1:0]                 len_reg;
    logic [LEN_W-1:0]                 pos_reg;
    logic                             ovf_reg;
    logic                             busy_reg;
    logic                             valid_reg;
    logic                             err_reg;
    logic                             dir_down_reg;
    logic [RAIL_W-1:0]                rail_reg;
    logic [RAIL_W-1:0]                rails_m1_reg;
    logic [D_WIDTH-1:0]               data_reg;
    logic [D_WIDTH-1:0]               mem [MAX_NOF_CHARS];

    logic [MAX_RAILS-1:0][LEN_W-1:0]  ptr_vec;
    logic [MAX_RAILS:0][LEN_W-1:0]    start_sum;

    logic              token_acc;
    logic              char_acc;
    logic              pass_thru;
    logic              bad_key;
    logic              issue;
    logic [CMP_W-1:0]  key_ext;
    logic [CMP_W-1:0]  len_ext;
    logic [LEN_W-1:0]  rd_addr;
    logic [RAIL_W-1:0] rail_next;
    logic              dir_next;

    assign token_acc = (state_reg == IDLE) && valid_i && (data_i == START_DECRYPTION_TOKEN);
    assign char_acc  = (state_reg == IDLE) && valid_i && (data_i != START_DECRYPTION_TOKEN)
                       && (len_reg < LEN_W'(MAX_NOF_CHARS));
    assign key_ext   = CMP_W'(key);
    assign len_ext   = CMP_W'(len_reg);
    assign pass_thru = (key_ext <= CMP_W'(1)) || (key_ext >= len_ext);
    assign bad_key   = !pass_thru && (key_ext > CMP_W'(MAX_RAILS));
    assign issue     = (state_reg == OUTPUT) && (!valid_reg || ready_i) && (pos_reg != len_reg);
    assign rd_addr   = ptr_vec[rail_reg];

    // A single rail (rails_m1 == 0) degenerates the walk to buffer order.
    always_comb begin
        rail_next = '0;
        dir_next  = 1'b1;
        if (rails_m1_reg != '0) begin
            if (dir_down_reg) begin
                if (rail_reg == rails_m1_reg) begin
                    rail_next = rail_reg - RAIL_W'(1);
                    dir_next  = 1'b0;
                end else begin
                    rail_next = rail_reg + RAIL_W'(1);
                    dir_next  = 1'b1;
                end
            end else begin
                if (rail_reg == '0) begin
                    rail_next = rail_reg + RAIL_W'(1);
                    dir_next  = 1'b1;
                end else begin
                    rail_next = rail_reg - RAIL_W'(1);
                    dir_next  = 1'b0;
                end
            end
        end
    end

    assign start_sum[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_RAILS; gi++) begin : g_rail
            logic [LEN_W-1:0] cnt_reg;
            logic [LEN_W-1:0] ptr_reg;

            assign start_sum[gi+1] = start_sum[gi] + cnt_reg;
            assign ptr_vec[gi]     = ptr_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                    ptr_reg <= '0;
                end else begin
                    if (token_acc)
                        cnt_reg <= '0;
                    else if (state_reg == COUNT && rail_reg == RAIL_W'(gi))
                        cnt_reg <= cnt_reg + LEN_W'(1);

                    if (state_reg == PREFIX)
                        ptr_reg <= start_sum[gi];
                    else if (issue && rail_reg == RAIL_W'(gi))
                        ptr_reg <= ptr_reg + LEN_W'(1);
                end
            end
        end
    endgenerate

    // Message buffer with registered read feeding data_o directly.
    always_ff @(posedge clk) begin
        if (char_acc)
            mem[len_reg[ADDR_W-1:0]] <= data_i;
        if (!rst_n)
            data_reg <= '0;
        else if (issue)
            data_reg <= mem[rd_addr[ADDR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            len_reg      <= '0;
            pos_reg      <= '0;
            ovf_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            valid_reg    <= 1'b0;
            err_reg      <= 1'b0;
            dir_down_reg <= 1'b1;
            rail_reg     <= '0;
            rails_m1_reg <= '0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (token_acc) begin
                        ovf_reg      <= 1'b0;
                        rails_m1_reg <= pass_thru ? '0 : RAIL_W'(key_ext - CMP_W'(1));
                        rail_reg     <= '0;
                        dir_down_reg <= 1'b1;
                        pos_reg      <= '0;
                        if (len_reg != '0) begin
                            if (bad_key) begin
                                err_reg <= 1'b1;
                                len_reg <= '0;
                            end else begin
                                err_reg   <= ovf_reg;
                                busy_reg  <= 1'b1;
                                state_reg <= COUNT;
                            end
                        end
                    end else if (valid_i) begin
                        if (char_acc)
                            len_reg <= len_reg + LEN_W'(1);
                        else
                            ovf_reg <= 1'b1;
                    end
                end
                COUNT: begin
                    rail_reg     <= rail_next;
                    dir_down_reg <= dir_next;
                    pos_reg      <= pos_reg + LEN_W'(1);
                    if (pos_reg == len_reg - LEN_W'(1))
                        state_reg <= PREFIX;
                end
                PREFIX: begin
                    rail_reg     <= '0;
                    dir_down_reg <= 1'b1;
                    pos_reg      <= '0;
                    state_reg    <= OUTPUT;
                end
                OUTPUT: begin
                    if (issue) begin
                        valid_reg    <= 1'b1;
                        rail_reg     <= rail_next;
                        dir_down_reg <= dir_next;
                        pos_reg      <= pos_reg + LEN_W'(1);
                    end else if (valid_reg && ready_i) begin
                        // Final beat accepted: every position has been issued.
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        len_reg   <= '0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy    = busy_reg;
    assign data_o  = data_reg;
    assign valid_o = valid_reg;
    assign err_o   = err_reg;
endmodule

// File: tb/tb_rail_fence_decryptor.sv
// Directed bench for rail_fence_decryptor; a position-sorting rail fence
// model supplies expected plaintext, checked beat by beat.
module tb_rail_fence_decryptor;
    localparam int MAXN = 64;
    typedef logic [7:0] ch_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_i = 1'b0;
    logic       ready_i = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic [7:0] key = 8'h00;
    logic       busy;
    logic [7:0] data_o;
    logic       valid_o;
    logic       err_o;

    always #5 clk = ~clk;

    rail_fence_decryptor #(
        .D_WIDTH(8), .KEY_WIDTH(8), .MAX_NOF_CHARS(MAXN), .MAX_RAILS(8),
        .START_DECRYPTION_TOKEN(8'hFA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .key(key),
        .ready_i(ready_i), .busy(busy), .data_o(data_o), .valid_o(valid_o), .err_o(err_o)
    );

    int  n_pass = 0;
    int  n_total = 0;
    int  beat_cnt = 0;
    int  err_cnt = 0;
    int  ready_mode = 0;
    int  ridx = 0;
    ch_t cipher_q[$];
    ch_t plain_q[$];
    ch_t exp_q[$];
    logic stall_prev = 1'b0;
    ch_t  held = 8'h00;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int rail_of(input int p, input int k);
        int per;
        int m;
        per = 2 * (k - 1);
        m = p % per;
        return (m < k) ? m : per - m;
    endfunction

    // Plaintext position order sorted by rail gives the ciphertext order.
    task automatic model(input int k);
        int L;
        int order[$];
        L = cipher_q.size();
        plain_q = cipher_q;
        if (k > 1 && k < L) begin
            for (int r = 0; r < k; r++)
                for (int p = 0; p < L; p++)
                    if (rail_of(p, k) == r) order.push_back(p);
            for (int j = 0; j < L; j++) plain_q[order[j]] = cipher_q[j];
        end
    endtask

    task automatic load(input string s);
        cipher_q.delete();
        for (int i = 0; i < s.len(); i++) cipher_q.push_back(ch_t'(s[i]));
    endtask

    task automatic pin(input string c, input int k, input string p);
        load(c);
        model(k);
        check({"pin_len_", p}, plain_q.size(), p.len());
        for (int i = 0; i < p.len() && i < plain_q.size(); i++)
            check($sformatf("pin_%s_%0d", p, i), plain_q[i], ch_t'(p[i]));
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (err_o) err_cnt++;
            if (stall_prev) begin
                check("hold_valid", valid_o, 1);
                check("hold_data", data_o, held);
            end
            if (valid_o && ready_i) begin
                check("beat_available", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("beat_data", data_o, exp_q.pop_front());
                beat_cnt++;
            end
            stall_prev = valid_o && !ready_i;
            held = data_o;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            ready_i = (ready_mode == 0) ? 1'b1 : (ridx % 3 == 0);
            ridx++;
        end
    end

    task automatic send_chars_and_token(input int k);
        foreach (cipher_q[i]) begin
            valid_i = 1'b1;
            data_i = cipher_q[i];
            tick();
        end
        valid_i = 1'b1;
        data_i = 8'hFA;
        key = 8'(k);
        tick();
        valid_i = 1'b0;
        key = ~8'(k);
    endtask

    task automatic run_msg(input string name, input int k);
        int n, L, exp_err, exp_beats, b0, e0, first;
        bit ovf, bad, busy_seen, done;
        n = cipher_q.size();
        L = (n > MAXN) ? MAXN : n;
        ovf = n > MAXN;
        bad = (L > 0) && (k >= 2) && (k < L) && (k > 8);
        exp_err = ((L > 0) && (ovf || bad)) ? 1 : 0;
        exp_beats = (L == 0 || bad) ? 0 : L;
        b0 = beat_cnt;
        e0 = err_cnt;
        foreach (cipher_q[i]) begin
            valid_i = 1'b1;
            data_i = cipher_q[i];
            tick();
        end
        while (cipher_q.size() > MAXN) void'(cipher_q.pop_back());
        model(k);
        if (exp_beats > 0) foreach (plain_q[i]) exp_q.push_back(plain_q[i]);
        valid_i = 1'b1;
        data_i = 8'hFA;
        key = 8'(k);
        tick();
        valid_i = 1'b0;
        key = ~8'(k);
        first = -1;
        busy_seen = 1'b0;
        done = 1'b0;
        for (int cyc = 1; cyc <= L * 4 + 40 && !done; cyc++) begin
            tick();
            if (cyc == 1 && exp_beats > 0) check({name, "_busy_rise"}, busy, 1);
            if (busy) busy_seen = 1'b1;
            if (valid_o && first < 0) first = cyc;
            if (busy) begin
                valid_i = 1'b1;
                data_i = 8'h41 + 8'(cyc % 20);
                key = 8'($urandom_range(0, 255));
            end else begin
                valid_i = 1'b0;
            end
            if (cyc >= 4 && !busy && !valid_o && (beat_cnt - b0) == exp_beats) done = 1'b1;
        end
        valid_i = 1'b0;
        check({name, "_completed"}, done, 1);
        check({name, "_beats"}, beat_cnt - b0, exp_beats);
        check({name, "_err_pulses"}, err_cnt - e0, exp_err);
        if (exp_beats > 0) check({name, "_first_valid_in_time"}, (first > 0) && (first <= L + 4), 1);
        else check({name, "_busy_never"}, busy_seen, 0);
        check({name, "_leftover"}, exp_q.size(), 0);
        exp_q.delete();
        $display("msg %s key=%0d L=%0d beats=%0d err=%0d first_valid=%0d",
                 name, k, L, beat_cnt - b0, err_cnt - e0, first);
    endtask

    task automatic run_str(input string s, input int k);
        load(s);
        run_msg(s, k);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b0;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_valid", valid_o, 0);
        check("rst_err", err_o, 0);
        check("rst_data", data_o, 0);
        rst_n = 1'b1;
        tick();

        pin("HLOEL", 2, "HELLO");
        pin("WECRLTEERDSOEEFEAOCAIVDEN", 3, "WEAREDISCOVEREDFLEEATONCE");
        pin("HOLELWRDLO", 3, "HELLOWORLD");
        pin("HOEWRLOLLD", 4, "HELLOWORLD");
        pin("ABC", 5, "ABC");

        run_str("HLOEL", 2);
        run_str("WECRLTEERDSOEEFEAOCAIVDEN", 3);
        run_str("ABC", 1);
        run_str("ABC", 5);
        run_str("HOEWRLOLLD", 4);
        run_str("THEQUICKBROWNFOXJUMP", 8);
        run_str("THEQUICKBROWNFOXJUMP", 20);
        run_str("THEQUICKBROWNFOXJUMP", 9);
        run_str("", 3);

        cipher_q.delete();
        for (int i = 0; i < 70; i++) cipher_q.push_back(8'h41 + 8'((i * 7) % 26));
        run_msg("overflow70", 2);

        ready_mode = 1;
        run_str("HLOEL", 2);
        ready_mode = 0;

        // Reset right after the second plaintext beat.
        load("HLOEL");
        model(2);
        foreach (plain_q[i]) exp_q.push_back(plain_q[i]);
        b0 = beat_cnt;
        send_chars_and_token(2);
        for (int cyc = 0; cyc < 60 && (beat_cnt - b0) < 2; cyc++) tick();
        check("reset_two_beats_seen", beat_cnt - b0, 2);
        rst_n = 1'b0;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_valid", valid_o, 0);
        check("midrst_err", err_o, 0);
        check("midrst_data", data_o, 0);
        rst_n = 1'b1;
        exp_q.delete();
        tick();
        $display("msg reset_after_beat2 beats_before_reset=%0d", beat_cnt - b0);
        run_str("HLOEL", 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
